// File: rtl/pipe_ctrl_sched_pkg.sv
// Shared pipeline-control definitions: scheduler states, PC source codes, trap vectors
// and the control-word bundle. The PC mux and CP0 logic reuse these definitions.
package pipe_ctrl_sched_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MEM_WAIT  = 2'd1,
        ST_IRQ_DRAIN = 2'd2,
        ST_IRQ_VEC   = 2'd3
    } state_t;

    localparam logic [2:0] PC_SEL_SEQ = 3'd0;
    localparam logic [2:0] PC_SEL_BR  = 3'd1;
    localparam logic [2:0] PC_SEL_JMP = 3'd2;
    localparam logic [2:0] PC_SEL_EXC = 3'd3;
    localparam logic [2:0] PC_SEL_IRQ = 3'd4;

    localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;
    localparam logic [31:0] IRQ_VECTOR = 32'h8000_0200;

    // Winning request in RUN, highest priority first
    typedef enum logic [2:0] {
        ACT_NONE, ACT_MEM, ACT_EXC, ACT_IRQ, ACT_BR, ACT_JMP, ACT_LU
    } act_t;

    typedef struct packed {
        logic       pc_we;
        logic       ifid_we;
        logic       ifid_flush;
        logic       idex_flush;
        logic       exmem_flush;
        logic       pipe_hold;
        logic [2:0] pc_sel;
        logic       epc_we;
        logic       mem_to_err;
    } ctrl_t;

    function automatic ctrl_t ctrl_flow();
        ctrl_t c;
        c         = '0;
        c.pc_we   = 1'b1;
        c.ifid_we = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t ctrl_exc();
        ctrl_t c;
        c             = ctrl_flow();
        c.pc_sel      = PC_SEL_EXC;
        c.epc_we      = 1'b1;
        c.ifid_flush  = 1'b1;
        c.idex_flush  = 1'b1;
        c.exmem_flush = 1'b1;
        return c;
    endfunction

    // Front end frozen, one bubble injected into ID/EX
    function automatic ctrl_t ctrl_bubble();
        ctrl_t c;
        c            = '0;
        c.idex_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sched.sv
// Central stall/flush scheduler for the 5-stage pipeline: arbitrates hazard and redirect
// requests, sequences interrupt entry and watches for data-memory wait timeouts.
module pipe_ctrl_sched
    import pipe_ctrl_sched_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 15,
    parameter int unsigned CNT_W        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lu_req,
    input  logic       jmp_id,
    input  logic       br_taken,
    input  logic       exc_req,
    input  logic       irq,
    input  logic       irq_en,
    input  logic       mem_busy,
    output logic       pc_we,
    output logic       ifid_we,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       pipe_hold,
    output logic [2:0] pc_sel,
    output logic       epc_we,
    output logic       mem_to_err
);

    localparam logic [CNT_W:0] TO_LIM    = (CNT_W+1)'(MEM_TIMEOUT);
    localparam logic [CNT_W:0] DRAIN_LIM = (CNT_W+1)'(DRAIN_CYCLES);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W:0]   cnt_inc;
    act_t             act;
    ctrl_t            ctrl;

    // cnt holds the cycles already spent in the current wait/drain window, so cnt_inc
    // is the ordinal of the current cycle; one spare bit keeps the compare overflow-free.
    assign cnt_inc = {1'b0, cnt} + 1'b1;

    always_comb begin
        act = ACT_NONE;
        if (mem_busy)           act = ACT_MEM;
        else if (exc_req)       act = ACT_EXC;
        else if (irq && irq_en) act = ACT_IRQ;
        else if (br_taken)      act = ACT_BR;
        else if (jmp_id)        act = ACT_JMP;
        else if (lu_req)        act = ACT_LU;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_RUN: begin
                if (act == ACT_MEM) begin
                    state_nxt = ST_MEM_WAIT;
                    cnt_nxt   = CNT_W'(1);
                end else if (act == ACT_IRQ) begin
                    // The accept cycle is itself the first drain cycle
                    if (DRAIN_CYCLES <= 1) begin
                        state_nxt = ST_IRQ_VEC;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_IRQ_DRAIN;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_busy) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else if (cnt_inc == TO_LIM) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt_inc[CNT_W-1:0];
                end
            end
            ST_IRQ_DRAIN: begin
                if (mem_busy) begin
                    cnt_nxt = cnt;
                end else if (exc_req) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else if (cnt_inc == DRAIN_LIM) begin
                    state_nxt = ST_IRQ_VEC;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc[CNT_W-1:0];
                end
            end
            ST_IRQ_VEC: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        ctrl = ctrl_flow();
        case (state)
            ST_RUN: begin
                case (act)
                    ACT_MEM: begin
                        ctrl           = '0;
                        ctrl.pipe_hold = 1'b1;
                    end
                    ACT_EXC: ctrl = ctrl_exc();
                    ACT_IRQ: ctrl = ctrl_bubble();
                    ACT_BR: begin
                        ctrl.pc_sel     = PC_SEL_BR;
                        ctrl.ifid_flush = 1'b1;
                        ctrl.idex_flush = 1'b1;
                    end
                    ACT_JMP: begin
                        ctrl.pc_sel     = PC_SEL_JMP;
                        ctrl.ifid_flush = 1'b1;
                    end
                    ACT_LU:  ctrl = ctrl_bubble();
                    default: ctrl = ctrl_flow();
                endcase
            end
            ST_MEM_WAIT: begin
                if (mem_busy) begin
                    ctrl            = '0;
                    ctrl.pipe_hold  = 1'b1;
                    ctrl.mem_to_err = (cnt_inc == TO_LIM);
                end
            end
            ST_IRQ_DRAIN: begin
                if (mem_busy) begin
                    ctrl           = ctrl_bubble();
                    ctrl.pipe_hold = 1'b1;
                end else if (exc_req) begin
                    ctrl = ctrl_exc();
                end else begin
                    ctrl = ctrl_bubble();
                end
            end
            ST_IRQ_VEC: begin
                ctrl.pc_sel     = PC_SEL_IRQ;
                ctrl.epc_we     = 1'b1;
                ctrl.ifid_flush = 1'b1;
            end
            default: ctrl = ctrl_flow();
        endcase

        if (reset) begin
            ctrl             = '0;
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.exmem_flush = 1'b1;
        end
    end

    assign pc_we       = ctrl.pc_we;
    assign ifid_we     = ctrl.ifid_we;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_flush = ctrl.exmem_flush;
    assign pipe_hold   = ctrl.pipe_hold;
    assign pc_sel      = ctrl.pc_sel;
    assign epc_we      = ctrl.epc_we;
    assign mem_to_err  = ctrl.mem_to_err;

endmodule

// File: tb/tb_pipe_ctrl_sched.sv
// Bench for pipe_ctrl_sched: directed scenarios then random traffic, all checked
// cycle by cycle against an episode-based reference model.
module tb_pipe_ctrl_sched;

    localparam int DRAIN = 2;
    localparam int TMO   = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lu_req = 1'b0, jmp_id = 1'b0, br_taken = 1'b0, exc_req = 1'b0;
    logic       irq = 1'b0, irq_en = 1'b0, mem_busy = 1'b0;
    logic       pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pipe_hold;
    logic [2:0] pc_sel;
    logic       epc_we, mem_to_err;

    always #5 clk = ~clk;

    pipe_ctrl_sched #(.DRAIN_CYCLES(DRAIN), .MEM_TIMEOUT(TMO), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .lu_req(lu_req), .jmp_id(jmp_id), .br_taken(br_taken),
        .exc_req(exc_req), .irq(irq), .irq_en(irq_en), .mem_busy(mem_busy),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .pipe_hold(pipe_hold), .pc_sel(pc_sel),
        .epc_we(epc_we), .mem_to_err(mem_to_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int to_pulses = 0;

    // Reference model: which episode the pipeline is in, measured in elapsed cycles
    int wait_len   = 0;   // busy cycles seen in the current memory wait, 0 = none
    int drain_done = -1;  // drain cycles completed, -1 = no interrupt entry in progress
    bit vec_now    = 0;   // interrupt vector cycle is due

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [10:0] pk(input logic a, input logic b, input logic c, input logic d,
                                        input logic f, input logic g, input logic [2:0] s,
                                        input logic h, input logic i);
        return {a, b, c, d, f, g, s, h, i};
    endfunction

    task automatic ref_step(output logic [10:0] e);
        logic [10:0] exc_o, bub_o;
        exc_o = pk(1, 1, 1, 1, 1, 0, 3'd3, 1, 0);
        bub_o = pk(0, 0, 0, 1, 0, 0, 3'd0, 0, 0);
        e     = pk(1, 1, 0, 0, 0, 0, 3'd0, 0, 0);
        if (reset) begin
            e = pk(0, 0, 1, 1, 1, 0, 3'd0, 0, 0);
            wait_len = 0; drain_done = -1; vec_now = 0;
        end else if (vec_now) begin
            e = pk(1, 1, 1, 0, 0, 0, 3'd4, 1, 0);
            vec_now = 0;
        end else if (wait_len > 0) begin
            if (mem_busy) begin
                wait_len++;
                e = pk(0, 0, 0, 0, 0, 1, 3'd0, 0, (wait_len % TMO) == 0);
            end else begin
                wait_len = 0;
            end
        end else if (drain_done >= 0) begin
            if (mem_busy) e = pk(0, 0, 0, 1, 0, 1, 3'd0, 0, 0);
            else if (exc_req) begin
                e = exc_o; drain_done = -1;
            end else begin
                e = bub_o; drain_done++;
                if (drain_done >= DRAIN) begin vec_now = 1; drain_done = -1; end
            end
        end else begin
            if (mem_busy) begin
                e = pk(0, 0, 0, 0, 0, 1, 3'd0, 0, 0); wait_len = 1;
            end else if (exc_req) e = exc_o;
            else if (irq && irq_en) begin
                e = bub_o; drain_done = 1;
                if (drain_done >= DRAIN) begin vec_now = 1; drain_done = -1; end
            end else if (br_taken) e = pk(1, 1, 1, 1, 0, 0, 3'd1, 0, 0);
            else if (jmp_id)       e = pk(1, 1, 1, 0, 0, 0, 3'd2, 0, 0);
            else if (lu_req)       e = bub_o;
        end
    endtask

    // Drive one cycle's inputs, then compare the settled Mealy outputs before the next edge
    task automatic cyc(input string tag, input logic rst, input logic mb, input logic ex,
                       input logic iq, input logic en, input logic br, input logic jp,
                       input logic lu);
        logic [10:0] e;
        @(negedge clk);
        reset = rst; mem_busy = mb; exc_req = ex; irq = iq; irq_en = en;
        br_taken = br; jmp_id = jp; lu_req = lu;
        #1;
        ref_step(e);
        if (mem_to_err) to_pulses++;
        chk(tag, {21'd0, pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pipe_hold,
                  pc_sel, epc_we, mem_to_err}, {21'd0, e});
    endtask

    initial begin
        int burst;
        burst = 0;

        repeat (3) cyc("reset", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("idle_after_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("lu_bubble", 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("lu_release", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("br_wins", 0, 0, 0, 0, 0, 1, 1, 1);
        cyc("jmp_only", 0, 0, 0, 0, 0, 0, 1, 0);

        to_pulses = 0;
        repeat (20) cyc("mem_wait", 0, 1, 0, 0, 0, 0, 0, 0);
        chk("timeout_pulses_20", 32'(to_pulses), 32'd1);
        cyc("mem_release", 0, 0, 1, 0, 0, 1, 0, 0);
        cyc("after_release", 0, 0, 0, 0, 0, 0, 0, 0);

        cyc("irq_accept", 0, 0, 0, 1, 1, 0, 0, 0);
        cyc("irq_drain", 0, 0, 0, 1, 1, 0, 0, 0);
        cyc("irq_vec", 0, 0, 0, 0, 1, 0, 0, 0);
        cyc("irq_done", 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (2) cyc("irq_masked", 0, 0, 0, 1, 0, 0, 0, 0);

        cyc("irq_accept2", 0, 0, 0, 1, 1, 0, 0, 0);
        cyc("exc_in_drain", 0, 0, 1, 0, 1, 0, 0, 0);
        repeat (3) cyc("no_vec_after_exc", 0, 0, 0, 0, 1, 0, 0, 0);

        cyc("irq_accept3", 0, 0, 0, 1, 1, 0, 0, 0);
        cyc("reset_mid_drain", 1, 0, 0, 0, 1, 0, 0, 0);
        repeat (3) cyc("after_reset_drain", 0, 0, 0, 0, 1, 0, 0, 0);

        cyc("irq_accept4", 0, 0, 0, 1, 1, 0, 0, 0);
        repeat (3) cyc("drain_mem_freeze", 0, 1, 0, 0, 1, 0, 0, 0);
        repeat (3) cyc("drain_resume", 0, 0, 0, 0, 1, 0, 0, 0);

        for (int i = 0; i < 4000; i++) begin
            logic rb, mb;
            rb = ($urandom_range(0, 299) == 0);
            if (burst > 0) begin
                mb = 1'b1; burst--;
            end else if ($urandom_range(0, 11) == 0) begin
                mb = 1'b1; burst = $urandom_range(0, 40);
            end else begin
                mb = 1'b0;
            end
            cyc("random", rb, mb, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
